vending_ctrl: RTL and testbench

VENDING_CTRL -- requirements
Module: vending_ctrl

---
 rtl/vending_ctrl.sv | 107 ++++++++++
 tb/tb_vending_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl.sv
// Coin-operated vending controller: accumulates credit, vends at PRICE with change,
// refunds on cancel or idle timeout, and keeps a saturating count of sales.
module vending_ctrl #(
   parameter int unsigned PRICE   = 30,
   parameter int unsigned COIN1   = 5,
   parameter int unsigned COIN2   = 10,
   parameter int unsigned COIN3   = 25,
   parameter int unsigned CW      = 8,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned SW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          confirm,
   input  logic [1:0]    in,
   output logic [1:0]    out,
   output logic [CW-1:0] change,
   output logic [CW-1:0] credit,
   output logic          ready,
   output logic [SW-1:0] sold
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1) + 1;
   localparam logic [CW:0]   PRICE_W = PRICE[CW:0];
   localparam logic [CW-1:0] PRICE_C = PRICE[CW-1:0];
   localparam logic [TW-1:0] TMO_W   = TIMEOUT[TW-1:0];

   typedef enum logic [1:0] {IDLE, ACCUM, VEND, REFUND} state_t;

   state_t        state_q;
   logic [TW-1:0] tmo_q;
   logic [1:0]    out_q;
   logic [CW-1:0] change_q;
   logic [CW-1:0] credit_q;
   logic          ready_q;
   logic [SW-1:0] sold_q;

   function automatic logic [CW:0] coin_value(input logic [1:0] code);
      case (code)
         2'b01:   return COIN1[CW:0];
         2'b10:   return COIN2[CW:0];
         2'b11:   return COIN3[CW:0];
         default: return '0;
      endcase
   endfunction

   function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
      return (&v) ? v : v + SW'(1);
   endfunction

   logic [CW:0] next_sum;
   logic        coin_hit;
   logic        tmo_hit;
   logic        do_cancel;

   // Extra carry bit keeps credit+coin exact before comparing against PRICE.
   assign next_sum  = {1'b0, credit_q} + coin_value(in);
   assign coin_hit  = confirm && (in != 2'b00);
   assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_W);
   assign do_cancel = (state_q == ACCUM) && (confirm ? (in == 2'b00) : tmo_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         tmo_q    <= '0;
         out_q    <= 2'b00;
         change_q <= '0;
         credit_q <= '0;
         ready_q  <= 1'b1;
         sold_q   <= '0;
      end else if (state_q == VEND || state_q == REFUND) begin
         state_q  <= IDLE;
         out_q    <= 2'b00;
         change_q <= '0;
         ready_q  <= 1'b1;
         tmo_q    <= '0;
      end else if (do_cancel) begin
         state_q  <= REFUND;
         out_q    <= 2'b01;
         change_q <= credit_q;
         credit_q <= '0;
         ready_q  <= 1'b0;
      end else if (coin_hit) begin
         if (next_sum < PRICE_W) begin
            state_q  <= ACCUM;
            credit_q <= next_sum[CW-1:0];
            tmo_q    <= '0;
         end else begin
            state_q  <= VEND;
            out_q    <= (next_sum == PRICE_W) ? 2'b10 : 2'b11;
            change_q <= next_sum[CW-1:0] - PRICE_C;
            credit_q <= '0;
            ready_q  <= 1'b0;
            sold_q   <= sat_inc(sold_q);
         end
      end else if (state_q == ACCUM && TIMEOUT != 0) begin
         tmo_q <= tmo_q + TW'(1);
      end
   end

   assign out    = out_q;
   assign change = change_q;
   assign credit = credit_q;
   assign ready  = ready_q;
   assign sold   = sold_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Bench for vending_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_vending_ctrl;

   localparam int PRICE = 30;
   localparam int TMO   = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       confirm = 1'b0;
   logic [1:0] tb_in = 2'b00;

   logic [1:0]  out_a, out_b;
   logic [7:0]  change_a, change_b, credit_a, credit_b;
   logic        ready_a, ready_b;
   logic [15:0] sold_a;
   logic [1:0]  sold_b;

   vending_ctrl dut (
      .clk(clk), .rst(rst), .confirm(confirm), .in(tb_in),
      .out(out_a), .change(change_a), .credit(credit_a), .ready(ready_a), .sold(sold_a)
   );

   vending_ctrl #(.SW(2)) dut_sw2 (
      .clk(clk), .rst(rst), .confirm(confirm), .in(tb_in),
      .out(out_b), .change(change_b), .credit(credit_b), .ready(ready_b), .sold(sold_b)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 0;

   // model state: credit in cents, idle cycles since last coin, one-cycle busy flag
   int m_credit, m_idle, m_out, m_change, m_sold;
   bit m_busy;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
   endtask

   function automatic int coin_val(input logic [1:0] code);
      case (code)
         2'b01:   return 5;
         2'b10:   return 10;
         2'b11:   return 25;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_credit = 0; m_idle = 0; m_out = 0; m_change = 0; m_sold = 0; m_busy = 0;
   endtask

   task automatic model_edge(input logic c, input logic [1:0] i);
      int v;
      if (m_busy) begin
         m_busy = 0; m_out = 0; m_change = 0;
      end else if (c && i != 2'b00) begin
         v = m_credit + coin_val(i);
         if (v < PRICE) begin
            m_credit = v; m_idle = 0;
         end else begin
            m_out = (v == PRICE) ? 2 : 3;
            m_change = v - PRICE;
            m_credit = 0; m_sold++; m_busy = 1;
         end
      end else if (m_credit > 0 && (c || m_idle == TMO)) begin
         m_out = 1; m_change = m_credit; m_credit = 0; m_busy = 1;
      end else if (m_credit > 0) begin
         m_idle++;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out",      out_a,    m_out);
         chk("change",   change_a, m_change);
         chk("credit",   credit_a, m_credit);
         chk("ready",    ready_a,  m_busy ? 0 : 1);
         chk("sold",     sold_a,   (m_sold > 65535) ? 65535 : m_sold);
         chk("out_sw2",  out_b,    m_out);
         chk("cred_sw2", credit_b, m_credit);
         chk("sold_sw2", sold_b,   (m_sold > 3) ? 3 : m_sold);
      end
   end

   task automatic step(input logic c, input logic [1:0] i);
      confirm = c;
      tb_in   = i;
      @(posedge clk);
      model_edge(c, i);
      #1;
   endtask

   task automatic rst_pulse();
      #1 rst = 1'b1;
      #1;
      chk("rst_out",    out_a,    0);
      chk("rst_credit", credit_a, 0);
      chk("rst_change", change_a, 0);
      chk("rst_ready",  ready_a,  1);
      chk("rst_sold",   sold_a,   0);
      chk("rst_sold2",  sold_b,   0);
      rst = 1'b0;
      model_reset();
   endtask

   int quiet;

   initial begin
      model_reset();
      #12;
      chk("init_out",    out_a,    0);
      chk("init_credit", credit_a, 0);
      chk("init_ready",  ready_a,  1);
      chk("init_sold",   sold_a,   0);
      #1 rst = 1'b0;
      chk_en = 1;

      // exact-price sale
      step(1, 2'b01); chk("d1_credit", credit_a, 5);
      step(1, 2'b01); chk("d1_credit", credit_a, 10);
      step(1, 2'b10); chk("d1_credit", credit_a, 20);
      step(1, 2'b10);
      chk("d1_out", out_a, 2); chk("d1_change", change_a, 0);
      chk("d1_sold", sold_a, 1); chk("d1_ready", ready_a, 0);
      step(0, 2'b00); chk("d1_idle_out", out_a, 0);

      // sale with change
      step(1, 2'b10);
      step(1, 2'b11);
      chk("d2_out", out_a, 3); chk("d2_change", change_a, 5); chk("d2_credit", credit_a, 0);
      step(0, 2'b00); chk("d2_idle_out", out_a, 0);

      // cancel refund, then cancel in IDLE
      step(1, 2'b01);
      step(1, 2'b10);
      step(1, 2'b00);
      chk("d3_out", out_a, 1); chk("d3_change", change_a, 15);
      step(0, 2'b00); chk("d3_out_after", out_a, 0);
      step(1, 2'b00); chk("d3_idle_cancel", out_a, 0); chk("d3_idle_change", change_a, 0);

      // timeout refund, then coin on the expiry edge
      step(1, 2'b01);
      for (int k = 0; k < 16; k++) step(0, 2'b00);
      chk("d4_pre_out", out_a, 0); chk("d4_pre_credit", credit_a, 5);
      step(0, 2'b00);
      chk("d4_tmo_out", out_a, 1); chk("d4_tmo_change", change_a, 5);
      step(0, 2'b00);
      step(1, 2'b01);
      for (int k = 0; k < 16; k++) step(0, 2'b00);
      step(1, 2'b01);
      chk("d4_exp_credit", credit_a, 10); chk("d4_exp_out", out_a, 0);
      step(1, 2'b00);
      step(0, 2'b00);

      // coin during VEND is ignored
      step(1, 2'b11);
      step(1, 2'b01); chk("d5_out", out_a, 2);
      step(1, 2'b10); chk("d5_vend_credit", credit_a, 0); chk("d5_vend_out", out_a, 0);
      step(0, 2'b00); chk("d5_idle_credit", credit_a, 0);

      // async reset mid-ACCUM, then saturating sold on the SW=2 instance
      step(1, 2'b10);
      rst_pulse();
      for (int s = 0; s < 5; s++) begin
         step(1, 2'b11);
         step(1, 2'b01);
         step(0, 2'b00);
      end
      chk("d6_sold2", sold_b, 3);
      chk("d6_sold",  sold_a, 5);

      // randomized traffic
      quiet = 0;
      for (int n = 0; n < 3000; n++) begin
         if (quiet > 0) begin
            quiet--;
            step(0, 2'($urandom_range(0, 3)));
         end else if ($urandom_range(0, 29) == 0) begin
            quiet = $urandom_range(10, 20);
            step(0, 2'b00);
         end else begin
            step(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)));
         end
         if ($urandom_range(0, 199) == 0) rst_pulse();
      end

      @(negedge clk);
      chk_en = 0;
      #2;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
